// File: rtl/delay_pipe_pkg.sv
// Shared defaults and the depth clamp used by the elastic delay pipeline.
// cfg_depth of 0 maps to 1 and anything beyond the physical stage count maps to that count.
package delay_pipe_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 4;

    function automatic int unsigned clamp_depth(input int unsigned cfg, input int unsigned max_depth);
        if (cfg == 0) begin
            return 1;
        end
        if (cfg > max_depth) begin
            return max_depth;
        end
        return cfg;
    endfunction

endpackage

// File: rtl/elastic_stage.sv
// One pipeline slot: a data register plus its valid bit.
// The data register only captures valid items, so an emptied slot keeps its last value.
module elastic_stage
    import delay_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_en_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_en_i) begin
            valid_d = valid_i;
        end
        if (load_en_i && valid_i && !clr_i) begin
            data_d = data_i;
        end
        // A clear drops the item but leaves the data register untouched.
        if (clr_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/elastic_delay_pipeline.sv
// Elastic delay line: nominal depth_q-cycle latency with valid/ready flow control,
// bubble collapsing, synchronous flush, occupancy count and runtime-selectable depth.
module elastic_delay_pipeline
    import delay_pipe_pkg::*;
#(
    parameter  int WIDTH     = DEFAULT_WIDTH,
    parameter  int MAX_DEPTH = DEFAULT_DEPTH,
    localparam int CW        = $clog2(MAX_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CW-1:0]    cfg_depth,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    occupancy,
    output logic [CW-1:0]    depth_q
);

    logic [MAX_DEPTH-1:0] v;
    logic [MAX_DEPTH-1:0] r;
    logic [WIDTH-1:0]     d [MAX_DEPTH];

    logic [CW-1:0] entry_idx;
    logic [CW-1:0] occ_q, occ_d;
    logic [CW-1:0] depth_d;
    logic          entry_ready;
    logic          in_xfer, out_xfer;

    assign entry_idx = depth_q - CW'(1);

    for (genvar gi = 0; gi < MAX_DEPTH; gi++) begin : g_stage
        localparam logic [CW-1:0] IDX = CW'(gi);

        logic             is_entry;
        logic             src_v;
        logic [WIDTH-1:0] src_d;

        // Stage i may advance whenever some slot at or below it is free or the consumer pulls.
        assign r[gi]    = out_ready | ~(&v[gi:0]);
        assign is_entry = (entry_idx == IDX);

        if (gi == MAX_DEPTH - 1) begin : g_top
            assign src_v = in_valid & is_entry;
            assign src_d = in_data;
        end else begin : g_mid
            // Slots above the entry stage are always empty, so shifting from them only moves bubbles.
            assign src_v = is_entry ? in_valid : v[gi+1];
            assign src_d = is_entry ? in_data  : d[gi+1];
        end

        elastic_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .clr_i    (flush),
            .load_en_i(r[gi]),
            .valid_i  (src_v),
            .data_i   (src_d),
            .valid_o  (v[gi]),
            .data_o   (d[gi])
        );
    end

    always_comb begin
        entry_ready = 1'b0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (entry_idx == CW'(i)) begin
                entry_ready = r[i];
            end
        end
    end

    assign in_ready  = entry_ready & ~flush;
    assign in_xfer   = in_valid & in_ready;
    assign out_valid = v[0];
    assign out_data  = d[0];
    assign out_xfer  = v[0] & out_ready;

    always_comb begin
        occ_d   = occ_q;
        depth_d = depth_q;
        if (flush) begin
            occ_d = '0;
        end else if (in_xfer && !out_xfer) begin
            occ_d = occ_q + CW'(1);
        end else if (!in_xfer && out_xfer) begin
            occ_d = occ_q - CW'(1);
        end
        // Depth may only move while nothing is in flight, so no item sees two latencies.
        if ((occ_q == '0 || flush) && !in_xfer) begin
            depth_d = CW'(clamp_depth(32'(cfg_depth), MAX_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q   <= '0;
            depth_q <= CW'(MAX_DEPTH);
        end else begin
            occ_q   <= occ_d;
            depth_q <= depth_d;
        end
    end

    assign occupancy = occ_q;

endmodule
